// File: rtl/player_state_pkg.sv
// rtl/player_state_pkg.sv - shared heading/rotation encodings, FSM state type and map dimensions
package player_state_pkg;

  localparam int MAP_W_DEF = 16;
  localparam int MAP_H_DEF = 16;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam logic [1:0] ROT_NONE = 2'b00;
  localparam logic [1:0] ROT_CW   = 2'b01;
  localparam logic [1:0] ROT_CCW  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_COMMIT
  } player_fsm_t;

endpackage

// File: rtl/player_step_calc.sv
// rtl/player_step_calc.sv - one-cell forward target, bounds check and wall-map address
module player_step_calc
  import player_state_pkg::*;
#(
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  logic [XW-1:0]    pos_x,
  input  logic [YW-1:0]    pos_y,
  input  logic [1:0]       heading,
  output logic [XW-1:0]    target_x,
  output logic [YW-1:0]    target_y,
  output logic             out_of_bounds,
  output logic [XW+YW-1:0] cell_addr
);

  localparam logic [XW:0] X_ONE = 1;
  localparam logic [YW:0] Y_ONE = 1;

  logic [XW:0] tx_ext;
  logic [YW:0] ty_ext;

  // The extra top bit catches both wrap below zero and overflow past a power-of-two edge.
  always_comb begin
    tx_ext = {1'b0, pos_x};
    ty_ext = {1'b0, pos_y};
    case (heading)
      DIR_N:   ty_ext = {1'b0, pos_y} - Y_ONE;
      DIR_E:   tx_ext = {1'b0, pos_x} + X_ONE;
      DIR_S:   ty_ext = {1'b0, pos_y} + Y_ONE;
      default: tx_ext = {1'b0, pos_x} - X_ONE;
    endcase
  end

  assign out_of_bounds = tx_ext[XW] | ty_ext[YW];
  assign target_x      = tx_ext[XW-1:0];
  assign target_y      = ty_ext[YW-1:0];
  // MAP_W is a power of two, so y*MAP_W + x is a plain concatenation.
  assign cell_addr     = {target_y, target_x};

endmodule

// File: rtl/player_state.sv
// rtl/player_state.sv - player pose register with wall-checked forward moves
module player_state
  import player_state_pkg::*;
#(
  parameter int MAP_W     = MAP_W_DEF,
  parameter int MAP_H     = MAP_H_DEF,
  parameter int START_X   = 1,
  parameter int START_Y   = 1,
  parameter int START_DIR = 0,
  localparam int XW = $clog2(MAP_W),
  localparam int YW = $clog2(MAP_H),
  localparam int AW = $clog2(MAP_W * MAP_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          move,
  input  logic [1:0]    rotation,
  output logic          map_rd_req,
  output logic [AW-1:0] map_addr,
  input  logic          map_rd_ack,
  input  logic          map_wall,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [1:0]    heading,
  output logic          pose_update,
  output logic          move_blocked,
  output logic          busy
);

  player_fsm_t   state;
  logic          prev_move;
  logic [1:0]    prev_rot;
  logic [XW-1:0] tgt_x;
  logic [YW-1:0] tgt_y;
  logic          commit_ok;

  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic          step_oob;
  logic [AW-1:0] step_addr;

  logic move_edge;
  logic rot_edge;

  player_step_calc #(
    .XW (XW),
    .YW (YW)
  ) u_step (
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .heading       (heading),
    .target_x      (step_x),
    .target_y      (step_y),
    .out_of_bounds (step_oob),
    .cell_addr     (step_addr)
  );

  assign move_edge = move & ~prev_move;
  assign rot_edge  = (prev_rot == ROT_NONE) && ((rotation == ROT_CW) || (rotation == ROT_CCW));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      prev_move    <= 1'b0;
      prev_rot     <= ROT_NONE;
      pos_x        <= XW'(START_X);
      pos_y        <= YW'(START_Y);
      heading      <= 2'(START_DIR);
      tgt_x        <= '0;
      tgt_y        <= '0;
      commit_ok    <= 1'b0;
      map_rd_req   <= 1'b0;
      map_addr     <= '0;
      pose_update  <= 1'b0;
      move_blocked <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Edge history tracks the inputs even while busy so held levels never fire late.
      prev_move    <= move;
      prev_rot     <= rotation;
      pose_update  <= 1'b0;
      move_blocked <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (move_edge) begin
            if (step_oob) begin
              move_blocked <= 1'b1;
            end else begin
              tgt_x      <= step_x;
              tgt_y      <= step_y;
              map_addr   <= step_addr;
              map_rd_req <= 1'b1;
              busy       <= 1'b1;
              state      <= ST_REQ;
            end
          end else if (rot_edge) begin
            heading     <= (rotation == ROT_CW) ? heading + 2'd1 : heading - 2'd1;
            pose_update <= 1'b1;
          end
        end
        ST_REQ: begin
          if (map_rd_ack) begin
            map_rd_req <= 1'b0;
            commit_ok  <= ~map_wall;
            state      <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (commit_ok) begin
            pos_x       <= tgt_x;
            pos_y       <= tgt_y;
            pose_update <= 1'b1;
          end else begin
            move_blocked <= 1'b1;
          end
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          map_rd_req <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_state.sv
// tb/tb_player_state.sv - directed self-checking bench for player_state
module tb_player_state;

  logic       clk;
  logic       rst;
  logic       move;
  logic [1:0] rotation;
  logic       map_rd_req;
  logic [7:0] map_addr;
  logic       map_rd_ack;
  logic       map_wall;
  logic [3:0] pos_x;
  logic [3:0] pos_y;
  logic [1:0] heading;
  logic       pose_update;
  logic       move_blocked;
  logic       busy;

  int passed = 0;
  int total  = 0;
  int pulses;

  player_state dut (
    .clk          (clk),
    .rst          (rst),
    .move         (move),
    .rotation     (rotation),
    .map_rd_req   (map_rd_req),
    .map_addr     (map_addr),
    .map_rd_ack   (map_rd_ack),
    .map_wall     (map_wall),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .heading      (heading),
    .pose_update  (pose_update),
    .move_blocked (move_blocked),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_pose(input string tag, input int x, input int y, input int h);
    chk({tag, ".x"}, 32'(pos_x), 32'(x));
    chk({tag, ".y"}, 32'(pos_y), 32'(y));
    chk({tag, ".h"}, 32'(heading), 32'(h));
  endtask

  task automatic pulse_rot(input logic [1:0] r);
    rotation = r;
    tick();
    pulses += int'(pose_update);
    rotation = 2'b00;
    tick();
    pulses += int'(pose_update);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; move = 1'b0; rotation = 2'b00; map_rd_ack = 1'b0; map_wall = 1'b0;
    tick(); tick();
    chk_pose("reset", 1, 1, 0);
    chk("reset.req", 32'(map_rd_req), 0);
    chk("reset.addr", 32'(map_addr), 0);
    chk("reset.upd", 32'(pose_update), 0);
    chk("reset.blk", 32'(move_blocked), 0);
    chk("reset.busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Held CW for three cycles fires once.
    rotation = 2'b01;
    pulses = 0;
    repeat (3) begin tick(); pulses += int'(pose_update); end
    chk("cw_hold.h", 32'(heading), 1);
    chk("cw_hold.pulses", 32'(pulses), 1);
    rotation = 2'b00;
    tick();

    pulse_rot(2'b10);
    chk("ccw.back_to_n", 32'(heading), 0);
    rotation = 2'b10;
    tick();
    chk("ccw_wrap.h", 32'(heading), 3);
    chk("ccw_wrap.upd", 32'(pose_update), 1);
    rotation = 2'b00;
    tick();
    chk("ccw_wrap.upd_off", 32'(pose_update), 0);

    pulses = 0;
    repeat (4) pulse_rot(2'b01);
    chk("cw4.h", 32'(heading), 3);
    chk("cw4.pulses", 32'(pulses), 4);

    // Clear forward move East from (1,1): target (2,1), addr 18.
    pulse_rot(2'b01);
    pulse_rot(2'b01);
    chk("face_e.h", 32'(heading), 1);
    move = 1'b1;
    tick();
    chk("mv_clear.req", 32'(map_rd_req), 1);
    chk("mv_clear.addr", 32'(map_addr), 18);
    chk("mv_clear.busy", 32'(busy), 1);
    repeat (3) begin
      tick();
      chk("mv_clear.req_hold", 32'(map_rd_req), 1);
      chk("mv_clear.addr_hold", 32'(map_addr), 18);
    end
    map_rd_ack = 1'b1; map_wall = 1'b0;
    tick();
    map_rd_ack = 1'b0;
    chk("mv_clear.req_drop", 32'(map_rd_req), 0);
    chk_pose("mv_clear.ack", 1, 1, 1);
    tick();
    chk_pose("mv_clear.commit", 2, 1, 1);
    chk("mv_clear.upd", 32'(pose_update), 1);
    chk("mv_clear.busy_off", 32'(busy), 0);
    tick();
    chk("mv_clear.upd_off", 32'(pose_update), 0);
    move = 1'b0;
    tick();

    // Same move into a wall.
    do_reset();
    pulse_rot(2'b01);
    move = 1'b1;
    tick();
    chk("mv_wall.addr", 32'(map_addr), 18);
    map_rd_ack = 1'b1; map_wall = 1'b1;
    tick();
    map_rd_ack = 1'b0; map_wall = 1'b0;
    pulses = 0;
    tick();
    chk("mv_wall.blk", 32'(move_blocked), 1);
    chk("mv_wall.upd", 32'(pose_update), 0);
    chk_pose("mv_wall", 1, 1, 1);
    tick();
    chk("mv_wall.blk_off", 32'(move_blocked), 0);
    move = 1'b0;
    tick();

    // Walk to (1,0) facing N, then step off the top edge.
    pulse_rot(2'b10);
    move = 1'b1;
    tick();
    chk("mv_n.addr", 32'(map_addr), 1);
    map_rd_ack = 1'b1;
    tick();
    map_rd_ack = 1'b0;
    tick();
    chk_pose("mv_n", 1, 0, 0);
    move = 1'b0;
    tick();
    move = 1'b1;
    tick();
    chk("oob.blk", 32'(move_blocked), 1);
    chk("oob.req", 32'(map_rd_req), 0);
    chk("oob.busy", 32'(busy), 0);
    pulses = 0;
    repeat (3) begin tick(); pulses += int'(map_rd_req) + int'(move_blocked); end
    chk("oob.quiet", 32'(pulses), 0);
    move = 1'b0;
    tick();

    // Rotation during REQ is dropped; reset aborts; late ack is ignored.
    do_reset();
    move = 1'b1;
    tick();
    chk("abort.req", 32'(map_rd_req), 1);
    rotation = 2'b01;
    tick();
    chk("abort.rot_dropped", 32'(heading), 0);
    move = 1'b0; rotation = 2'b00;
    rst = 1'b1;
    #1;
    chk("abort.async_req", 32'(map_rd_req), 0);
    chk("abort.async_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    map_rd_ack = 1'b1;
    tick();
    map_rd_ack = 1'b0;
    tick();
    chk_pose("abort.late_ack", 1, 1, 0);
    chk("abort.upd", 32'(pose_update), 0);
    chk("abort.blk", 32'(move_blocked), 0);
    chk("abort.busy", 32'(busy), 0);

    // Simultaneous move and rotation: move wins; the held rotation never fires.
    move = 1'b1; rotation = 2'b01;
    tick();
    chk("prio.req", 32'(map_rd_req), 1);
    chk("prio.h", 32'(heading), 0);
    map_rd_ack = 1'b1; map_wall = 1'b1;
    tick();
    map_rd_ack = 1'b0; map_wall = 1'b0;
    tick();
    chk("prio.blk", 32'(move_blocked), 1);
    tick();
    chk("prio.held_rot", 32'(heading), 0);
    chk("prio.held_upd", 32'(pose_update), 0);
    move = 1'b0; rotation = 2'b00;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/player_state.md
Name: player_state

Overview:
- Consumes the `move` / `rotation` command pair produced by the button-decoding movement logic.
- Maintains the player's grid position and heading, and checks forward moves against the wall map through a req/ack read port.
- Publishes the committed pose to the ray caster, with a one-cycle update strobe whenever the pose changes.

Parameters:
- MAP_W, 16, map width in cells (power of two).
- MAP_H, 16, map height in cells (power of two).
- START_X, 1, reset X cell.
- START_Y, 1, reset Y cell.
- START_DIR, 0, reset heading (0=N, 1=E, 2=S, 3=W).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- move  in  1  forward-step command level.
- rotation  in  2  00 none, 01 CW90, 10 CCW90, 11 ignored.
- map_rd_req  out  1  wall-map read request.
- map_addr  out  log2(MAP_W*MAP_H)  cell index = y*MAP_W + x.
- map_rd_ack  in  1  read data valid this cycle.
- map_wall  in  1  1 = target cell is a wall; sampled only when map_rd_ack=1.
- pos_x  out  log2(MAP_W)  committed X.
- pos_y  out  log2(MAP_H)  committed Y.
- heading  out  2  committed heading.
- pose_update  out  1  one-cycle pulse: pose changed.
- move_blocked  out  1  one-cycle pulse: forward move rejected.
- busy  out  1  high while FSM not in IDLE.

Behaviour:
- Reset values: pos_x=START_X, pos_y=START_Y, heading=START_DIR, map_rd_req=0, map_addr=0, pose_update=0, move_blocked=0, busy=0, FSM=IDLE, prev_cmd=0.
- Edge detection:
  - Register prev_move and prev_rot every cycle.
  - An action is triggered by a 0→1 on move, or by rotation changing from 00 to 01 or 10.
  - Held levels do not repeat the action.
- Priority: if move and rotation rise in the same cycle, move wins and the rotation is discarded.
- Command acceptance:
  - Commands are accepted only in IDLE.
  - Edges arriving while busy are dropped, not queued.
  - prev registers still update while busy, so a level held across busy does not fire on return to IDLE.
- FSM states: IDLE, REQ, COMMIT.
- IDLE, rotation accepted in cycle N:
  - heading ← heading+1 (CW) or heading−1 (CCW), mod 4 (3+1→0, 0−1→3).
  - pose_update=1 in cycle N+1.
  - FSM stays in IDLE.
- IDLE, move accepted in cycle N:
  - Compute target = pos + unit vector(heading): N: y−1, E: x+1, S: y+1, W: x−1.
  - If the target leaves the map (x=0 facing W, x=MAP_W−1 facing E, y=0 facing N, y=MAP_H−1 facing S): no read is issued, move_blocked=1 in cycle N+1, FSM stays in IDLE.
  - Otherwise latch the target, drive map_addr, set map_rd_req=1 from cycle N+1, and go to REQ.
- REQ:
  - map_rd_req and map_addr are held stable until map_rd_ack=1.
  - In the ack cycle M, map_rd_req drops at the end of M and the FSM moves to COMMIT.
  - If map_wall=0, the target is latched for commit; if map_wall=1, it is discarded.
- COMMIT (cycle M+1):
  - Clear: pos ← target and pose_update=1.
  - Wall: pos is unchanged and move_blocked=1.
  - Return to IDLE; a new command is accepted from cycle M+2.
- No timeout: REQ waits indefinitely.
- pose_update and move_blocked are mutually exclusive and never longer than one cycle.
- map_rd_ack outside REQ is ignored.
- Reset mid-operation (any state):
  - Immediate return to reset values.
  - An in-flight ack arriving after reset release is ignored, because the FSM is in IDLE.
- Arithmetic:
  - Target coordinates are computed with one extra bit to detect underflow/overflow.
  - Outputs are never wider than log2(MAP_W) / log2(MAP_H).

Decomposition:
- Shared package (also used by the ray caster and the movement decoder):
  - heading encoding constants DIR_N/E/S/W.
  - rotation encoding ROT_NONE/ROT_CW/ROT_CCW.
  - FSM state typedef.
  - map-dimension constants.
- One sub-module: `player_step_calc`, a combinational block that takes (pos_x, pos_y, heading) and produces target_x, target_y, out_of_bounds and cell address.

Test Plan:
- Reset release with defaults → pos=(1,1), heading=0, all pulses 0; rotation=01 for 3 cycles → heading=1, exactly one pose_update.
- heading=0, rotation=10 pulsed 1 cycle → heading=3 (wrap); repeat 4× CW → heading back to 3, 4 pose_update pulses.
- pos=(1,1), heading=E, move rises, map_rd_ack after 3 cycles with map_wall=0 → map_addr=18 held through REQ; pos=(2,1); pose_update 1 cycle after ack.
- Same with map_wall=1 → pos stays (1,1); move_blocked pulses once; pose_update stays 0.
- pos=(1,0), heading=N, move rises → no map_rd_req ever; move_blocked in the next cycle.
- Move issued, then a rotation edge during REQ, then rst asserted before ack, then a late ack → rotation dropped; after reset, pose=(1,1,0); late ack causes no change.
